// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow clock-like input in clk cycles, with
// tolerance, lock and stall reporting. Define CLK_PERIOD_METER_SYNC_EN for asynchronous i_sig.
module clk_period_meter #(
    parameter int CNT_W    = 16,
    parameter int EXPECTED = 10,
    parameter int TOL      = 0,
    parameter int TIMEOUT  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_sig,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_mismatch,
    output logic             o_lock,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   EXP_X = (CNT_W+1)'(EXPECTED);
    localparam logic [CNT_W:0]   TOL_X = (CNT_W+1)'(TOL);

    state_t           state, state_nxt;
    logic             s, prev;
    logic [CNT_W-1:0] cnt, hl, cnt_inc;
    logic [1:0]       good_cnt, good_nxt;
    logic             rise, fall, cnt_sat, mm_now;
    logic             report, tmo_hit, latch_high;
    logic [CNT_W:0]   cnt_x, diff;

    // s and prev reset high so a signal already high at reset release is not a rise
`ifdef CLK_PERIOD_METER_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            s      <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], i_sig};
            s      <= sync_q[1];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) s <= 1'b1;
        else     s <= i_sig;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) prev <= 1'b1;
        else     prev <= s;
    end

    assign rise    = s & ~prev;
    assign fall    = ~s & prev;
    assign cnt_sat = &cnt;
    assign cnt_inc = cnt_sat ? cnt : cnt + 1'b1;
    assign cnt_x   = {1'b0, cnt};
    assign diff    = (cnt_x >= EXP_X) ? (cnt_x - EXP_X) : (EXP_X - cnt_x);
    assign mm_now  = cnt_sat || (diff > TOL_X);
    assign good_nxt = mm_now ? 2'd0 : ((good_cnt == 2'd2) ? 2'd2 : good_cnt + 2'd1);

    always_ff @(posedge clk) begin
        if (rst) state <= SYNC_WAIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        report     = 1'b0;
        tmo_hit    = 1'b0;
        latch_high = 1'b0;
        case (state)
            SYNC_WAIT: if (rise) state_nxt = MEAS_HIGH;
            MEAS_HIGH: begin
                if (fall) begin
                    latch_high = 1'b1;
                    state_nxt  = MEAS_LOW;
                end else if (cnt >= TMO) begin
                    tmo_hit   = 1'b1;
                    state_nxt = SYNC_WAIT;
                end
            end
            MEAS_LOW: begin
                if (rise) begin
                    report    = 1'b1;
                    state_nxt = MEAS_HIGH;
                end else if (cnt >= TMO) begin
                    tmo_hit   = 1'b1;
                    state_nxt = SYNC_WAIT;
                end
            end
            default: state_nxt = SYNC_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            hl  <= '0;
        end else begin
            if (rise)                    cnt <= CNT_W'(1);
            else if (tmo_hit)            cnt <= '0;
            else if (state != SYNC_WAIT) cnt <= cnt_inc;
            if (latch_high) hl <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_period   <= '0;
            o_high     <= '0;
            o_valid    <= 1'b0;
            o_mismatch <= 1'b0;
            o_lock     <= 1'b0;
            o_timeout  <= 1'b0;
            good_cnt   <= 2'd0;
        end else begin
            o_valid <= report;
            if (report) begin
                o_period   <= cnt;
                o_high     <= hl;
                o_mismatch <= mm_now;
                o_timeout  <= 1'b0;
                good_cnt   <= good_nxt;
                o_lock     <= (good_nxt == 2'd2);
            end else if (tmo_hit) begin
                o_timeout <= 1'b1;
                o_lock    <= 1'b0;
                good_cnt  <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: two instances (TOL=0 and TOL=2) share one stimulus.
module tb_clk_period_meter;

    logic clk = 1'b0;
    logic rst, i_sig;
    always #5 clk = ~clk;

    logic [15:0] period0, high0, period2, high2;
    logic        valid0, mm0, lock0, to0;
    logic        valid2, mm2, lock2, to2;

    clk_period_meter #(.CNT_W(16), .EXPECTED(10), .TOL(0), .TIMEOUT(1000)) dut0 (
        .clk(clk), .rst(rst), .i_sig(i_sig),
        .o_period(period0), .o_high(high0), .o_valid(valid0),
        .o_mismatch(mm0), .o_lock(lock0), .o_timeout(to0)
    );

    clk_period_meter #(.CNT_W(16), .EXPECTED(10), .TOL(2), .TIMEOUT(1000)) dut2 (
        .clk(clk), .rst(rst), .i_sig(i_sig),
        .o_period(period2), .o_high(high2), .o_valid(valid2),
        .o_mismatch(mm2), .o_lock(lock2), .o_timeout(to2)
    );

    int total = 0;
    int bad   = 0;
    int q_period[$], q_high[$], q_mm[$], q_lock[$], q_to[$], q_mm2[$], q_lock2[$];

    always @(negedge clk) begin
        if (valid0) begin
            q_period.push_back(int'(period0));
            q_high.push_back(int'(high0));
            q_mm.push_back(int'(mm0));
            q_lock.push_back(int'(lock0));
            q_to.push_back(int'(to0));
        end
        if (valid2) begin
            q_mm2.push_back(int'(mm2));
            q_lock2.push_back(int'(lock2));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic v, input int n);
        i_sig = v;
        repeat (n) tick();
    endtask

    task automatic clr();
        q_period.delete(); q_high.delete(); q_mm.delete(); q_lock.delete();
        q_to.delete(); q_mm2.delete(); q_lock2.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_period"}, period0, 0);
        chk({tag, "_high"}, high0, 0);
        chk({tag, "_valid"}, valid0, 0);
        chk({tag, "_mm"}, mm0, 0);
        chk({tag, "_lock"}, lock0, 0);
        chk({tag, "_to"}, to0, 0);
    endtask

    task automatic do_reset(input logic v);
        i_sig = v;
        rst   = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        clr();
    endtask

    task automatic p10(input int n);
        repeat (n) begin
            seg(1'b1, 5);
            seg(1'b0, 5);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v_tick, t_to;
        rst   = 1'b1;
        i_sig = 1'b0;

        // reset state
        i_sig = 1'b0;
        rst   = 1'b1;
        repeat (2) tick();
        chk_zero("rst");
        rst = 1'b0;
        clr();

        // clk/10, 50% duty
        seg(1'b0, 3);
        p10(3);
        seg(1'b1, 6);
        chk("t1_nvalid", q_period.size(), 3);
        if (q_period.size() >= 3) begin
            chk("t1_period", q_period[0], 10);
            chk("t1_high", q_high[0], 5);
            chk("t1_mm", q_mm[0], 0);
            chk("t1_lock_first", q_lock[0], 0);
            chk("t1_lock_second", q_lock[1], 1);
        end

        // high through reset release, then low 5 / high 3 / low 7
        do_reset(1'b1);
        seg(1'b1, 4);
        seg(1'b0, 5);
        seg(1'b1, 3);
        seg(1'b0, 7);
        seg(1'b1, 6);
        chk("t2_nvalid", q_period.size(), 1);
        if (q_period.size() >= 1) begin
            chk("t2_period", q_period[0], 10);
            chk("t2_high", q_high[0], 3);
            chk("t2_mm", q_mm[0], 0);
        end

        // lock, one 12-cycle period, then relock
        do_reset(1'b0);
        seg(1'b0, 3);
        p10(3);
        seg(1'b1, 6);
        seg(1'b0, 6);
        p10(2);
        seg(1'b1, 6);
        chk("t3_nvalid", q_period.size(), 6);
        chk("t3_nvalid2", q_mm2.size(), 6);
        if (q_period.size() >= 6 && q_mm2.size() >= 6) begin
            chk("t3_lock_pre", q_lock[2], 1);
            chk("t3_period12", q_period[3], 12);
            chk("t3_high12", q_high[3], 6);
            chk("t3_mm12", q_mm[3], 1);
            chk("t3_lock12", q_lock[3], 0);
            chk("t3_lock_p5", q_lock[4], 0);
            chk("t3_relock", q_lock[5], 1);
            chk("t3_mm_back", q_mm[5], 0);
            chk("t3_tol2_mm12", q_mm2[3], 0);
            chk("t3_tol2_lock12", q_lock2[3], 1);
        end

        // stall: frozen low after lock
        do_reset(1'b0);
        seg(1'b0, 3);
        p10(3);
        v_tick = -1;
        t_to   = -1;
        i_sig  = 1'b1;
        for (int k = 0; k < 1100; k++) begin
            tick();
            if (k == 4) i_sig = 1'b0;
            if (valid0 && v_tick < 0) v_tick = k;
            if (to0 && t_to < 0) t_to = k;
        end
        chk("t4_to_delay", t_to - v_tick, 1000);
        chk("t4_to_flag", to0, 1);
        chk("t4_lock_clr", lock0, 0);
        chk("t4_period_hold", period0, 10);
        chk("t4_no_valid", q_period.size(), 3);
        seg(1'b1, 5);
        seg(1'b0, 5);
        chk("t4_to_sticky", to0, 1);
        seg(1'b1, 6);
        chk("t4_nvalid", q_period.size(), 4);
        if (q_period.size() >= 4) begin
            chk("t4_resume_to", q_to[3], 0);
            chk("t4_resume_period", q_period[3], 10);
        end
        chk("t4_to_cleared", to0, 0);

        // reset mid-measurement, then a one-cycle glitch period
        do_reset(1'b0);
        seg(1'b0, 3);
        p10(2);
        seg(1'b1, 5);
        seg(1'b0, 2);
        chk("t5_lock_before", lock0, 1);
        rst = 1'b1;
        tick();
        chk_zero("t5_rst");
        rst = 1'b0;
        clr();
        seg(1'b0, 3);
        seg(1'b1, 1);
        seg(1'b0, 9);
        seg(1'b1, 6);
        chk("t5_nvalid", q_period.size(), 1);
        if (q_period.size() >= 1) begin
            chk("t5_period", q_period[0], 10);
            chk("t5_glitch_high", q_high[0], 1);
            chk("t5_mm", q_mm[0], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
